// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer backed by a word-addressed memory with wait states
//
// Ports:
//   PCLK     in   bus clock, rising-edge active
//   PRESETn  in   asynchronous active-low reset (clears FSM, outputs and memory)
//   PADDR    in   byte address
//   PSELx    in   completer select
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PWDATA   in   write data
//   PRDATA   out  read data, valid while PREADY=1 on a read
//   PREADY   out  transfer-complete strobe
//   PSLVERR  out  error response (misaligned or out-of-range), valid while PREADY=1

module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int LSB   = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  setup_err;

    assign idx = PADDR[LSB+IDX_W-1:LSB];

    // Byte-wide memories have no sub-word address bits to check.
    generate
        if (LSB > 0) begin : g_align
            assign misaligned = |PADDR[LSB-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    // Any address bit above the word index makes the access out of range.
    generate
        if (ADDR_WIDTH > LSB + IDX_W) begin : g_range
            assign out_of_range = |PADDR[ADDR_WIDTH-1:LSB+IDX_W];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign setup_err = misaligned | out_of_range;

    // Decoded purely from flops so the strobe cannot glitch on bus inputs.
    assign PREADY  = (state == ACCESS) && (cnt == 4'd0);
    assign PSLVERR = PREADY && err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            PRDATA  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // PENABLE without a preceding setup phase is ignored here.
                    if (PSELx && !PENABLE) begin
                        state   <= ACCESS;
                        idx_q   <= idx;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        err_q   <= setup_err;
                        cnt     <= 4'(WAIT_STATES);
                        // Read data is fetched at setup so it is stable for the
                        // whole access phase; writes leave PRDATA untouched.
                        if (!PWRITE) begin
                            PRDATA <= setup_err ? '0 : mem[idx];
                        end
                    end
                end
                ACCESS: begin
                    if (!PSELx) begin
                        // Abort: drop the transfer without touching memory.
                        state <= IDLE;
                    end else if (PENABLE) begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            if (write_q && !err_q) begin
                                mem[idx_q] <= wdata_q;
                            end
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
